// File: rtl/keypad_entry_controller.sv
// Keypad entry sequencer: debounces encoder digits into a BCD MM:SS setpoint; load/halt/reject strobe one cycle after the causing sample.
// Keypad locked out while RUNNING; `KEYPAD_SEC_CHECK_EN refuses starts with seconds tens above 5.
module keypad_entry_controller #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       validn,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       cook_done,
  output logic       enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       halt,
  output logic       reject,
  output logic       running
);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    RELEASE = 2'd1,
    RUNNING = 2'd2
  } state_t;

  localparam logic [7:0] DB = 8'(DEBOUNCE);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] prev_digit;
  logic       armed;

  logic       setpoint_zero;
  logic       start_ok;
  logic [7:0] press_len;
  logic [7:0] release_len;

  always_comb begin
    setpoint_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    start_ok      = start && armed;
    // Run length includes the current sample, so a press stable from its first cycle is accepted after DEBOUNCE samples.
    press_len     = 8'd0;
    if (!validn) begin
      if (cnt != 8'd0 && digit == prev_digit) begin
        press_len = cnt + 8'd1;
      end else begin
        press_len = 8'd1;
      end
    end
    release_len = validn ? (cnt + 8'd1) : 8'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ENTRY;
      cnt        <= 8'd0;
      prev_digit <= 4'd0;
      armed      <= 1'b1;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      load       <= 1'b0;
      halt       <= 1'b0;
      reject     <= 1'b0;
      running    <= 1'b0;
      enablen    <= 1'b0;
    end else begin
      load       <= 1'b0;
      halt       <= 1'b0;
      reject     <= 1'b0;
      prev_digit <= digit;
      // A start held across a RUNNING exit must be seen low before it can fire again.
      if (!start) begin
        armed <= 1'b1;
      end

      case (state)
        RUNNING: begin
          if (cook_done || stop || !door_closed) begin
            halt     <= !cook_done;
            state    <= ENTRY;
            cnt      <= 8'd0;
            running  <= 1'b0;
            enablen  <= 1'b0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end
        end

        default: begin
          if (stop) begin
            state    <= ENTRY;
            cnt      <= 8'd0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (start_ok && !door_closed) begin
            reject <= 1'b1;
`ifdef KEYPAD_SEC_CHECK_EN
          end else if (start_ok && !setpoint_zero && sec_tens > 4'd5) begin
            reject   <= 1'b1;
            state    <= ENTRY;
            cnt      <= 8'd0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
`endif
          end else if (start_ok && !setpoint_zero) begin
            load    <= 1'b1;
            running <= 1'b1;
            enablen <= 1'b1;
            armed   <= 1'b0;
            state   <= RUNNING;
            cnt     <= 8'd0;
          end else if (state == ENTRY) begin
            if (press_len == DB) begin
              min_tens <= min_ones;
              min_ones <= sec_tens;
              sec_tens <= sec_ones;
              sec_ones <= digit;
              state    <= RELEASE;
              cnt      <= 8'd0;
            end else begin
              cnt <= press_len;
            end
          end else begin
            if (release_len == DB) begin
              state <= ENTRY;
              cnt   <= 8'd0;
            end else begin
              cnt <= release_len;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_entry_controller.md
# keypad_entry_controller

Sequencing controller between the keypad priority encoder and the cook timer. It drives the encoder's active-low enable and debounces the encoder's `digit`/`validn` pair. Accepted digits shift into a 4-digit BCD MM:SS setpoint, and on a start command the setpoint is handed to the timer with a one-cycle load strobe. During cooking the keypad is locked out; stop, door-open or cook-done returns the block to entry.

## Interface
- `DEBOUNCE`, default 4: consecutive stable cycles needed to accept a press and to accept a release; legal range 1..255.

- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `digit`  in  4  BCD digit from the encoder
- `validn`  in  1  encoder valid, active-low
- `start`  in  1  start key, level, sampled each cycle
- `stop`  in  1  stop/clear key, level
- `door_closed`  in  1  1 = door closed
- `cook_done`  in  1  one-cycle pulse from the timer at countdown end
- `enablen`  out  1  encoder enable, active-low
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  setpoint digits
- `load`  out  1  one-cycle strobe: setpoint valid to the timer
- `halt`  out  1  one-cycle strobe: abort the timer
- `reject`  out  1  one-cycle strobe: start refused
- `running`  out  1  high while in RUNNING

## Operation
- Reset values: all digits 0, `load`/`halt`/`reject` 0, `running` 0, `enablen` 0, state ENTRY, debounce counter 0.
- States:
  - ENTRY: waiting for a press.
  - RELEASE: press accepted, waiting for release.
  - RUNNING: timer active.
- ENTRY press detection:
  - The counter increments each cycle `validn`=0 with `digit` equal to the previous cycle's `digit`.
  - The counter clears on `validn`=1 or on a digit change.
  - When the count reaches `DEBOUNCE`, the digits shift left and the digit enters `sec_ones`: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`. The old `min_tens` is discarded.
  - The state then goes to RELEASE and the counter clears.
- RELEASE: the counter counts cycles with `validn`=1. At `DEBOUNCE` the state returns to ENTRY. Any `validn`=0 clears the count. No digit is accepted in this state.
- Commands in ENTRY and RELEASE, in priority order:
  1. `stop` clears all digits, clears the counter, goes to ENTRY.
  2. `start` with `door_closed`=1 and a nonzero setpoint pulses `load`, goes to RUNNING and discards any pending debounce.
  3. `start` with `door_closed`=0 pulses `reject` and leaves the digits unchanged.
  4. `start` with a zero setpoint is ignored: no strobe.
- Commands act on the level of `start`/`stop`. A held `start` after RUNNING exits does not retrigger until `start` has been sampled low at least once. A held `stop` clears every cycle, which is harmless.
- RUNNING:
  - `enablen`=1 and `running`=1; `digit`/`validn` are ignored.
  - `stop` or `door_closed`=0 pulses `halt`, clears the digits and goes to ENTRY.
  - `cook_done` clears the digits and goes to ENTRY with no `halt`.
  - If `cook_done` and `stop` arrive together, `cook_done` wins: no `halt`.
- Digits are always valid BCD (0..9); the encoder guarantees this.

## Timing
- A press stable from cycle t (first cycle sampled) updates the digits at the edge ending cycle t+`DEBOUNCE`-1 and is visible in cycle t+`DEBOUNCE`.
- `load` is asserted in the cycle after `start` is sampled, together with `running`=1. The setpoint is stable during `load` and for the whole of RUNNING.
- `halt` and `reject` are asserted for exactly one cycle, in the cycle after the causing sample.
- `enablen` rises in the same cycle as `running` and falls in the cycle after the exit event.
- `reset` asserted mid-press or mid-RUNNING returns the block to reset values at the next edge. No `halt` is issued; the timer shares `reset`.

## Configuration
- `KEYPAD_SEC_CHECK_EN`:
  - Defined: a start with `sec_tens` > 5 is refused. `reject` pulses, the digits are cleared, and the block stays in ENTRY. This check is evaluated after the door check.
  - Undefined: any nonzero setpoint loads, e.g. 0:90 is passed to the timer as is.

## Test plan
- `DEBOUNCE`=4, press 1 then 2 then 3 then 0, each held 6 cycles with 6-cycle releases → digits 1,2,3,0; `load` absent.
- Glitch: `validn` low for 3 cycles with digit 5, then high → digits unchanged. Then digit changes 5→6 mid-count → count restarts and only 6 is accepted after 4 stable cycles.
- Five presses 1,2,3,4,5 → digits 2,3,4,5.
- Setpoint 0,0,3,0 with `door_closed`=1 and `start` → `load` for one cycle, `running`=1, `enablen`=1. Then press 7 → ignored. Then `cook_done` → digits 0, `running`=0, no `halt`.
- RUNNING with `door_closed` dropping → `halt` for one cycle, ENTRY, digits 0. `start` with door open → `reject`, digits kept. `start` with setpoint 0 → no strobe.
- Setpoint 0,0,9,0 then `start`: with `KEYPAD_SEC_CHECK_EN` → `reject`, digits 0. Without it → `load`. `reset` mid-debounce → all reset values next cycle.
